fetch_branch_unit: RTL
======================

Name: fetch_branch_unit

Overview:
- Consumer side of the program-counter interface. Takes the 6-bit fetch address and the instruction ROM word every cycle.
- Forwards ordinary instructions to the execute stage with a valid strobe.
- Decodes control-flow instructions and drives the `branch`/`pc_target` pair back into the program counter.
- Owns the loop counter and the halt state. Sits between the program counter/ROM and the decode/execute path.

Parameters:
- INSTR_W, 16, instruction width; opcode is always bits [INSTR_W-1:INSTR_W-4].
- ADDR_W, 6, fetch address width (64-entry ROM); branch target is bits [ADDR_W-1:0] of the instruction.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- pc_addr  in  ADDR_W  current fetch address from the program counter.
- rom_data  in  INSTR_W  ROM word at pc_addr (combinational ROM read).
- zero_flag  in  1  ALU zero flag, used by BZ.
- branch  out  1  registered; 1 = program counter loads pc_target at the next edge.
- pc_target  out  ADDR_W  registered branch target.
- instr_out  out  INSTR_W  registered forwarded instruction.
- instr_addr  out  ADDR_W  address of instr_out.
- instr_valid  out  1  registered 1-cycle strobe per forwarded instruction.
- loop_cnt  out  ADDR_W  current loop counter.
- halted  out  1  1 while in HALT.

Behaviour:
- Reset (rst=1 at posedge):
  - All outputs become 0; state=RUN; fresh=1; last_addr=0.
  - rst overrides every state, including BRANCH and HALT.
- Opcodes:
  - C=JMP: unconditional branch.
  - D=BZ: branch if zero_flag=1.
  - E=DJNZ: decrement loop counter, branch if nonzero.
  - B=LDC: loop_cnt <= instr[ADDR_W-1:0].
  - F=HALT.
  - Every other opcode is ordinary and is forwarded.
  - Control opcodes (B–F) are consumed and never raise instr_valid.
- Accept rule, applied in RUN at each edge: the word is accepted iff fresh=1 or pc_addr != last_addr.
  - Accept sets last_addr<=pc_addr and fresh<=0.
  - This drops the duplicate address the program counter presents after reset and after every branch.
  - Non-accepted cycles: instr_valid=0, no state change.
- RUN, ordinary accepted word: next cycle instr_out=rom_data, instr_addr=pc_addr, instr_valid=1. Latency is 1 cycle from sample edge to strobe.
- RUN, taken branch (JMP; BZ with zero_flag=1; DJNZ taken):
  - Next cycle: branch=1, pc_target=target, instr_valid=0.
  - state->BRANCH.
- BRANCH, lasting exactly one cycle:
  - pc_addr holds the sequential shadow word; it is discarded unconditionally.
  - At the edge: branch<=0, fresh<=1, state->RUN.
  - Taken-branch penalty: shadow discarded, target accepted 2 edges after the branch accept.
- BZ with zero_flag=0: consumed, fall through, no branch.
- DJNZ:
  - loop_cnt=0: no decrement (no wrap), fall through.
  - loop_cnt=1: becomes 0, fall through.
  - loop_cnt>1: decrement and branch.
- LDC takes effect at the accept edge; an immediately following DJNZ sees the new value.
- HALT accepted:
  - state->HALT permanently until rst.
  - halted=1, branch=1, pc_target=HALT's own address every cycle, which pins the program counter.
  - No further accepts.
- Branch target equal to the shadow address or to itself: no special case; the shadow is still discarded and the target is re-fetched fresh.
- loop_cnt is unaffected by non-loop instructions and is cleared only by rst.

Test Plan:
- Reset, then ROM[0..3] = ordinary 16'h1000–16'h1003 → instr_valid pulses exactly 4 times, addresses 0,1,2,3 in order, no duplicate 0; branch stays 0.
- ROM[2]=16'hC00A (JMP 10), ROM[3]=16'h1333, ROM[10]=16'h1AAA → one-cycle branch=1 with pc_target=10; word 16'h1333 is never valid; next valid is 16'h1AAA at addr 10.
- ROM[4]=16'hD008 (BZ 8):
  - zero_flag=0 → falls through to addr 5, branch stays 0.
  - Rerun with zero_flag=1 → branch to 8.
- ROM[0]=16'hB003 (LDC 3), ROM[1]=ordinary 16'h1111, ROM[2]=16'hE001 (DJNZ 1) → 16'h1111 forwarded 3 times total; loop_cnt ends at 0; execution continues at addr 3.
- ROM[5]=16'hF000 (HALT) → halted=1, branch=1, pc_target=5 held for 20+ cycles, no instr_valid; rst → all outputs 0, fetch restarts at 0.
- rst asserted during the BRANCH cycle of a JMP → branch=0 next cycle, no instruction forwarded from the target, fresh fetch from addr 0.

Source files
------------

// File: rtl/fetch_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_branch_unit
// Purpose  : Accepts fetched ROM words, forwards ordinary instructions and
//            resolves JMP/BZ/DJNZ/LDC/HALT back into the program counter.
// Revision : 1.0  initial release
// ============================================================================
module fetch_branch_unit #(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               zero_flag,
    output logic               branch,
    output logic [ADDR_W-1:0]  pc_target,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_addr,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  loop_cnt,
    output logic               halted
);

    localparam logic [3:0]        c_OP_LDC  = 4'hB;
    localparam logic [3:0]        c_OP_JMP  = 4'hC;
    localparam logic [3:0]        c_OP_BZ   = 4'hD;
    localparam logic [3:0]        c_OP_DJNZ = 4'hE;
    localparam logic [3:0]        c_OP_HALT = 4'hF;
    localparam logic [ADDR_W-1:0] c_ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_BRANCH = 2'd1,
        S_HALT   = 2'd2
    } state_t;

    state_t               state_q,     state_d;
    logic                 fresh_q,     fresh_d;
    logic [ADDR_W-1:0]    last_addr_q, last_addr_d;
    logic                 branch_q,    branch_d;
    logic [ADDR_W-1:0]    target_q,    target_d;
    logic [INSTR_W-1:0]   instr_q,     instr_d;
    logic [ADDR_W-1:0]    iaddr_q,     iaddr_d;
    logic                 valid_q,     valid_d;
    logic [ADDR_W-1:0]    loop_q,      loop_d;

    logic [3:0]           w_opcode;
    logic [ADDR_W-1:0]    w_target;
    logic                 w_accept;
    logic                 w_take;

    assign w_opcode = rom_data[INSTR_W-1 -: 4];
    assign w_target = rom_data[ADDR_W-1:0];
    // A repeated address is the PC's stall after reset/branch, not a new instruction.
    assign w_accept = fresh_q || (pc_addr != last_addr_q);

    always_comb begin
        state_d     = state_q;
        fresh_d     = fresh_q;
        last_addr_d = last_addr_q;
        branch_d    = 1'b0;
        target_d    = target_q;
        instr_d     = instr_q;
        iaddr_d     = iaddr_q;
        valid_d     = 1'b0;
        loop_d      = loop_q;
        w_take      = 1'b0;

        case (state_q)
            S_RUN: begin
                if (w_accept) begin
                    last_addr_d = pc_addr;
                    fresh_d     = 1'b0;
                    case (w_opcode)
                        c_OP_JMP:  w_take = 1'b1;
                        c_OP_BZ:   w_take = zero_flag;
                        c_OP_DJNZ: begin
                            if (loop_q > c_ONE) begin
                                loop_d = loop_q - c_ONE;
                                w_take = 1'b1;
                            end else if (loop_q == c_ONE) begin
                                loop_d = '0;
                            end
                        end
                        c_OP_LDC:  loop_d = w_target;
                        c_OP_HALT: begin
                            state_d  = S_HALT;
                            branch_d = 1'b1;
                            target_d = pc_addr;
                        end
                        default: begin
                            instr_d = rom_data;
                            iaddr_d = pc_addr;
                            valid_d = 1'b1;
                        end
                    endcase
                    if (w_take) begin
                        branch_d = 1'b1;
                        target_d = w_target;
                        state_d  = S_BRANCH;
                    end
                end
            end
            S_BRANCH: begin
                // Shadow word on pc_addr is dropped; the target arrives fresh next cycle.
                fresh_d = 1'b1;
                state_d = S_RUN;
            end
            S_HALT: begin
                branch_d = 1'b1;
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            fresh_q     <= 1'b1;
            last_addr_q <= '0;
            branch_q    <= 1'b0;
            target_q    <= '0;
            instr_q     <= '0;
            iaddr_q     <= '0;
            valid_q     <= 1'b0;
            loop_q      <= '0;
        end else begin
            state_q     <= state_d;
            fresh_q     <= fresh_d;
            last_addr_q <= last_addr_d;
            branch_q    <= branch_d;
            target_q    <= target_d;
            instr_q     <= instr_d;
            iaddr_q     <= iaddr_d;
            valid_q     <= valid_d;
            loop_q      <= loop_d;
        end
    end

    assign branch      = branch_q;
    assign pc_target   = target_q;
    assign instr_out   = instr_q;
    assign instr_addr  = iaddr_q;
    assign instr_valid = valid_q;
    assign loop_cnt    = loop_q;
    assign halted      = (state_q == S_HALT);

endmodule
`default_nettype wire
